serieparalelo_align: RTL and testbench

- Parametrised successor to the 8-bit serial-to-parallel converter in the PCIe physical-layer receive path.
- Runs on the bit clock only. Word framing comes from an internal bit counter, not from a second divided clock.
- Finds word alignment by hunting for the COM symbol and requires LOCK_COUNT consecutive aligned COMs before declaring the lane active.
- Once active, delivers parallel words with a one-cycle strobe and a data-valid flag that is low for COM words.

---
 rtl/serieparalelo_align.sv | 108 ++++++++++
 tb/tb_serieparalelo_align.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serieparalelo_align.sv
// Bit-clock serial-to-parallel converter with COM-based word alignment.
// Hunts bit-by-bit for COM, confirms LOCK_COUNT aligned COMs, then emits framed words.
module serieparalelo_align #(
    parameter int             WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM      = WIDTH'(8'hBC),
    parameter int             LOCK_COUNT = 4,
    parameter bit             MSB_FIRST  = 1'b1
) (
    input  logic             clk32f,
    input  logic             reset,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             word_stb,
    output logic             valid,
    output logic             active
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT,
        COUNT,
        ACTIVE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [BW-1:0]    bitcnt;
    logic [CW-1:0]    com_cnt;
    logic [CW-1:0]    cnt_inc;
    logic             is_com;
    logic             boundary;
    logic             lock_hit;

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // cnt_inc saturates at LOCK_COUNT so com_cnt can never wrap
    always_comb begin
        sr_next    = MSB_FIRST ? {sr[WIDTH-2:0], in} : {in, sr[WIDTH-1:1]};
        is_com     = (sr == COM);
        boundary   = (bitcnt == '0);
        cnt_inc    = (com_cnt == CW'(LOCK_COUNT)) ? com_cnt : com_cnt + CW'(1);
        lock_hit   = (cnt_inc == CW'(LOCK_COUNT));
        state_next = state;
        case (state)
            HUNT: begin
                if (is_com) begin
                    state_next = (LOCK_COUNT == 1) ? ACTIVE : COUNT;
                end
            end
            COUNT: begin
                if (boundary) begin
                    if (!is_com) begin
                        state_next = HUNT;
                    end else if (lock_hit) begin
                        state_next = ACTIVE;
                    end
                end
            end
            ACTIVE: state_next = ACTIVE;
            default: state_next = HUNT;
        endcase
    end

    // A COM found while hunting defines the frame: the next word starts on the following bit
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            sr       <= '0;
            bitcnt   <= '0;
            com_cnt  <= '0;
            out      <= '0;
            word_stb <= 1'b0;
            valid    <= 1'b0;
            active   <= 1'b0;
        end else begin
            sr       <= sr_next;
            word_stb <= 1'b0;
            active   <= (state_next == ACTIVE);
            if (state == HUNT && is_com) begin
                bitcnt <= BW'(1);
            end else if (bitcnt == BW'(WIDTH - 1)) begin
                bitcnt <= '0;
            end else begin
                bitcnt <= bitcnt + BW'(1);
            end
            if (state == HUNT && is_com) begin
                com_cnt <= CW'(1);
            end else if (state == COUNT && boundary) begin
                com_cnt <= is_com ? cnt_inc : '0;
            end
            if (state == ACTIVE && boundary) begin
                out      <= sr;
                word_stb <= 1'b1;
                valid    <= !is_com;
            end
        end
    end

endmodule

// File: tb/tb_serieparalelo_align.sv
// Self-checking bench for serieparalelo_align: an 8-bit MSB-first instance and a
// 10-bit LSB-first instance, both checked against a stream-level alignment model.
module tb_serieparalelo_align;

    logic       clk32f = 1'b0;
    logic       reset  = 1'b0;
    logic       in8    = 1'b0;
    logic       in10   = 1'b0;
    logic [7:0] out8;
    logic       stb8, val8, act8;
    logic [9:0] out10;
    logic       stb10, val10, act10;

    int compared   = 0;
    int mismatched = 0;
    int lockEnd;

    bit          bits[$];
    logic [15:0] obsOut[$];
    bit          obsStb[$], obsVal[$], obsAct[$];
    logic [15:0] expOut[$];
    bit          expStb[$], expVal[$], expAct[$];

    serieparalelo_align #(.WIDTH(8), .COM(8'hBC), .LOCK_COUNT(4), .MSB_FIRST(1'b1)) dut8 (
        .clk32f(clk32f), .reset(reset), .in(in8),
        .out(out8), .word_stb(stb8), .valid(val8), .active(act8)
    );

    serieparalelo_align #(.WIDTH(10), .COM(10'h17C), .LOCK_COUNT(2), .MSB_FIRST(1'b0)) dut10 (
        .clk32f(clk32f), .reset(reset), .in(in10),
        .out(out10), .word_stb(stb10), .valid(val10), .active(act10)
    );

    always #5 clk32f = ~clk32f;

    // The w-bit word formed by the serial bits ending at stream index t
    function automatic logic [15:0] win(input int t, input int w, input bit msb);
        logic [15:0] v;
        int          idx;
        bit          b;
        v = '0;
        for (int i = 0; i < w; i++) begin
            idx = t - w + 1 + i;
            b   = (idx >= 0 && idx < bits.size()) ? bits[idx] : 1'b0;
            if (msb) v[w-1-i] = b;
            else     v[i]     = b;
        end
        return v;
    endfunction

    task automatic pushWord(input logic [15:0] v, input int w, input bit msb);
        for (int i = 0; i < w; i++) bits.push_back(msb ? v[w-1-i] : v[i]);
    endtask

    // Scans the stream for the lock point, then derives expected outputs after every edge
    task automatic buildModel(input int w, input logic [15:0] com, input int lockN, input bit msb);
        int          n, t, p, j, cnt, lend;
        bit          resumed, stb;
        logic [15:0] cur;
        bit          curVal;
        n = bits.size(); lend = -1; t = 0;
        while (t < n && lend < 0) begin
            if (win(t, w, msb) != com) begin
                t++;
            end else begin
                p = t; cnt = 1; resumed = 1'b0; j = 1;
                if (cnt >= lockN) lend = p;
                while (lend < 0 && !resumed && p + j * w < n) begin
                    if (win(p + j * w, w, msb) == com) begin
                        cnt++;
                        if (cnt >= lockN) lend = p + j * w;
                    end else begin
                        resumed = 1'b1;
                        t = p + j * w + 1;
                    end
                    j++;
                end
                if (lend < 0 && !resumed) t = n;
            end
        end
        lockEnd = lend;
        expOut.delete(); expStb.delete(); expVal.delete(); expAct.delete();
        cur = '0; curVal = 1'b0;
        for (int e = 0; e < n; e++) begin
            stb = (lend >= 0) && (e - 1 > lend) && (((e - 1 - lend) % w) == 0);
            if (stb) begin
                cur    = win(e - 1, w, msb);
                curVal = (cur != com);
            end
            expAct.push_back((lend >= 0) && (e >= lend + 1));
            expStb.push_back(stb);
            expOut.push_back(cur);
            expVal.push_back(curVal);
        end
    endtask

    // Resets both instances, streams bits into the selected one, records outputs after each edge
    task automatic applyStimulus(input bit sel);
        obsOut.delete(); obsStb.delete(); obsVal.delete(); obsAct.delete();
        reset = 1'b0; in8 = 1'b0; in10 = 1'b0;
        @(negedge clk32f);
        @(negedge clk32f);
        reset = 1'b1;
        if (sel) in10 = bits[0]; else in8 = bits[0];
        for (int e = 0; e < bits.size(); e++) begin
            @(posedge clk32f);
            @(negedge clk32f);
            obsOut.push_back(sel ? {6'd0, out10} : {8'd0, out8});
            obsStb.push_back(sel ? stb10 : stb8);
            obsVal.push_back(sel ? val10 : val8);
            obsAct.push_back(sel ? act10 : act8);
            if (e + 1 < bits.size()) begin
                if (sel) in10 = bits[e+1]; else in8 = bits[e+1];
            end
        end
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if ({out8, stb8, val8, act8} !== 11'd0 || {out10, stb10, val10, act10} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got %h/%b/%b/%b and %h/%b/%b/%b, need all zero",
                     out8, stb8, val8, act8, out10, stb10, val10, act10);
        end
        repeat (20) begin
            in8 = ($urandom_range(0, 1) == 1);
            @(negedge clk32f);
        end
        compared++;
        if ({out8, stb8, val8, act8} !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_held: got out=%h stb=%b valid=%b act=%b, need zeros", out8, stb8, val8, act8);
        end
    endtask

    task automatic test_lock_offset0();
        bits.delete();
        repeat (4) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'hA5, 8, 1'b1); pushWord(16'h3C, 8, 1'b1); pushWord(16'h0, 2, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL lock0 cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsOut[obsOut.size()-1] !== 16'h003C || obsVal[obsVal.size()-1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL lock0_final: got out=%h valid=%b, need out=3c valid=1",
                     obsOut[obsOut.size()-1], obsVal[obsVal.size()-1]);
        end
    endtask

    task automatic test_offset();
        bits.delete();
        repeat (3) bits.push_back($urandom_range(0, 1) == 1);
        repeat (4) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'h0F, 8, 1'b1); pushWord(16'h0, 2, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL offset cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsOut[obsOut.size()-1] !== 16'h000F) begin
            mismatched++;
            $display("[TB] FAIL offset_final: got out=%h, need out=0f", obsOut[obsOut.size()-1]);
        end
    endtask

    task automatic test_broken_lock();
        bits.delete();
        pushWord(16'hBC, 8, 1'b1); pushWord(16'hBC, 8, 1'b1); pushWord(16'h12, 8, 1'b1);
        repeat (4) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'h77, 8, 1'b1); pushWord(16'h0, 2, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL broken cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsAct[4*8] !== 1'b0 || obsOut[obsOut.size()-1] !== 16'h0077) begin
            mismatched++;
            $display("[TB] FAIL broken_final: got early act=%b out=%h, need act=0 out=77",
                     obsAct[4*8], obsOut[obsOut.size()-1]);
        end
    endtask

    task automatic test_com_active();
        bits.delete();
        repeat (5) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'h99, 8, 1'b1); pushWord(16'h0, 2, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL com_active cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsOut[obsOut.size()-1] !== 16'h0099 || obsVal[obsVal.size()-1] !== 1'b1 || obsAct[obsAct.size()-1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL com_active_final: got out=%h valid=%b act=%b, need out=99 valid=1 act=1",
                     obsOut[obsOut.size()-1], obsVal[obsVal.size()-1], obsAct[obsAct.size()-1]);
        end
    endtask

    task automatic test_reset_midstream();
        bits.delete();
        repeat (4) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'hA5, 8, 1'b1); pushWord(16'h0, 5, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL midstream_pre cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (act8 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midstream_active: got act=%b, need 1", act8);
        end
        #3 reset = 1'b0;
        #1;
        compared++;
        if ({out8, stb8, val8, act8} !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got out=%h stb=%b valid=%b act=%b, need zeros", out8, stb8, val8, act8);
        end
        bits.delete();
        repeat (4) pushWord(16'hBC, 8, 1'b1);
        pushWord(16'h55, 8, 1'b1); pushWord(16'h0, 2, 1'b1);
        applyStimulus(1'b0);
        buildModel(8, 16'hBC, 4, 1'b1);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL relock cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsOut[obsOut.size()-1] !== 16'h0055 || obsVal[obsVal.size()-1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL relock_final: got out=%h valid=%b, need out=55 valid=1",
                     obsOut[obsOut.size()-1], obsVal[obsVal.size()-1]);
        end
    endtask

    task automatic test_param_sweep();
        bits.delete();
        pushWord(16'h17C, 10, 1'b0); pushWord(16'h17C, 10, 1'b0);
        pushWord(16'h2A5, 10, 1'b0); pushWord(16'h0, 2, 1'b0);
        applyStimulus(1'b1);
        buildModel(10, 16'h17C, 2, 1'b0);
        for (int e = 0; e < bits.size(); e++) begin
            compared++;
            if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                mismatched++;
                $display("[TB] FAIL sweep cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                         e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
            end
        end
        compared++;
        if (obsOut[obsOut.size()-1] !== 16'h02A5 || obsVal[obsVal.size()-1] !== 1'b1 || obsAct[obsAct.size()-1] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sweep_final: got out=%h valid=%b act=%b, need out=2a5 valid=1 act=1",
                     obsOut[obsOut.size()-1], obsVal[obsVal.size()-1], obsAct[obsAct.size()-1]);
        end
    endtask

    task automatic test_random();
        int nCom;
        for (int it = 0; it < 6; it++) begin
            bits.delete();
            repeat ($urandom_range(0, 12)) bits.push_back($urandom_range(0, 1) == 1);
            nCom = $urandom_range(3, 5);
            repeat (nCom) pushWord(16'hBC, 8, 1'b1);
            repeat (3) pushWord(16'($urandom_range(0, 255)), 8, 1'b1);
            repeat ($urandom_range(2, 9)) bits.push_back($urandom_range(0, 1) == 1);
            applyStimulus(1'b0);
            buildModel(8, 16'hBC, 4, 1'b1);
            for (int e = 0; e < bits.size(); e++) begin
                compared++;
                if ({obsAct[e], obsStb[e], obsVal[e], obsOut[e]} !== {expAct[e], expStb[e], expVal[e], expOut[e]}) begin
                    mismatched++;
                    $display("[TB] FAIL random%0d cycle %0d: got act=%b stb=%b valid=%b out=%h, need act=%b stb=%b valid=%b out=%h",
                             it, e, obsAct[e], obsStb[e], obsVal[e], obsOut[e], expAct[e], expStb[e], expVal[e], expOut[e]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_lock_offset0();
        test_offset();
        test_broken_lock();
        test_com_active();
        test_reset_midstream();
        test_param_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
